// File: rtl/ahb_cmd_master_if.sv
// Command/response stream plus AHB-Lite master signals for ahb_cmd_master.
// Handshake: a command transfers on each rising edge where iCmdValid && oCmdReady; iCmdValid
// must not depend on oCmdReady, and command fields stay stable while valid is high and ready low.
// oRspValid is a one-cycle pulse per command, in command order, with no backpressure.
interface ahb_cmd_master_if;
  logic        iCmdValid;
  logic        oCmdReady;
  logic        iCmdWrite;
  logic [31:0] iCmdAddr;
  logic [31:0] iCmdWdata;
  logic        oRspValid;
  logic [31:0] oRspRdata;
  logic        oRspErr;
  logic        oBusy;
  logic        oHSEL;
  logic [1:0]  oHTRANS;
  logic        oHWRITE;
  logic [31:0] oHADDR;
  logic [2:0]  oHSIZE;
  logic [31:0] oHWDATA;
  logic        iHREADY;
  logic [31:0] iHRDATA;
  logic [1:0]  iHRESP;

  modport master (
    input  iCmdValid, iCmdWrite, iCmdAddr, iCmdWdata, iHREADY, iHRDATA, iHRESP,
    output oCmdReady, oRspValid, oRspRdata, oRspErr, oBusy,
           oHSEL, oHTRANS, oHWRITE, oHADDR, oHSIZE, oHWDATA
  );

  modport slave (
    output iCmdValid, iCmdWrite, iCmdAddr, iCmdWdata, iHREADY, iHRDATA, iHRESP,
    input  oCmdReady, oRspValid, oRspRdata, oRspErr, oBusy,
           oHSEL, oHTRANS, oHWRITE, oHADDR, oHSIZE, oHWDATA
  );
endinterface

// File: rtl/ahb_cmd_master.sv
// AHB-Lite initiator: command FIFO -> registered address stage -> data stage -> response pulse.
// Optional macro AHB_MST_ALIGN_CHECK_EN rejects misaligned addresses locally with an error response.
module ahb_cmd_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  ahb_cmd_master_if.master bus,
  output logic [1:0]       oDbgState
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  // Data-stage state: DS_ERR is the second (HREADY=1) cycle of a two-cycle ERROR response.
  typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_BUSY = 2'd1, DS_ERR = 2'd2} dstate_t;

  logic          memWrite [FIFO_DEPTH];
  logic [31:0]   memAddr  [FIFO_DEPTH];
  logic [31:0]   memWdata [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;

  logic          aValid, aWrite;
  logic [31:0]   aAddr;
  dstate_t       dState;
  logic          dWrite;
  logic [31:0]   dWdata;
  logic          rspValid, rspErr;
  logic [31:0]   rspRdata;

  logic          push, busPop, localPop, pop, errFirst;
  logic [AW-1:0] nextRd;
  logic [CW-1:0] remain;
  logic          nValid, nWrite, nLoad;
  logic [31:0]   nAddr;

  assign bus.oCmdReady = (count != CW'(FIFO_DEPTH));
  assign push          = bus.iCmdValid && bus.oCmdReady;
  assign busPop        = aValid && bus.iHREADY;
  assign errFirst      = (dState == DS_BUSY) && !bus.iHREADY && (bus.iHRESP == HRESP_ERROR);

`ifdef AHB_MST_ALIGN_CHECK_EN
  // Reject only when nothing is in flight so the error response stays in command order.
  assign localPop = (count != '0) && (memAddr[rdPtr][1:0] != 2'b00) && !aValid && (dState == DS_IDLE);
`else
  assign localPop = 1'b0;
`endif
  assign pop = busPop || localPop;

  // Head of the FIFO as it will stand after this edge; an empty FIFO bypasses the incoming command.
  always_comb begin
    nextRd = rdPtr + AW'(pop);
    remain = count - CW'(pop);
    nValid = 1'b0;
    nWrite = 1'b0;
    nAddr  = '0;
    if (remain != '0) begin
      nValid = 1'b1;
      nWrite = memWrite[nextRd];
      nAddr  = memAddr[nextRd];
    end else if (push) begin
      nValid = 1'b1;
      nWrite = bus.iCmdWrite;
      nAddr  = bus.iCmdAddr;
    end
`ifdef AHB_MST_ALIGN_CHECK_EN
    nLoad = nValid && (nAddr[1:0] == 2'b00);
`else
    nLoad = nValid;
`endif
  end

  always_ff @(posedge iClk) begin
    if (push) begin
      memWrite[wrPtr] <= bus.iCmdWrite;
      memAddr[wrPtr]  <= bus.iCmdAddr;
      memWdata[wrPtr] <= bus.iCmdWdata;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      aValid   <= 1'b0;
      aWrite   <= 1'b0;
      aAddr    <= '0;
      dState   <= DS_IDLE;
      dWrite   <= 1'b0;
      dWdata   <= '0;
      rspValid <= 1'b0;
      rspErr   <= 1'b0;
      rspRdata <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      // Address stage: cancel on an ERROR first cycle, hold during wait states, else reload.
      if (errFirst) begin
        aValid <= 1'b0;
      end else if (!(aValid && !bus.iHREADY)) begin
        aValid <= nLoad;
        if (nLoad) begin
          aWrite <= nWrite;
          aAddr  <= nAddr;
        end
      end

      if (bus.iHREADY) begin
        dState <= busPop ? DS_BUSY : DS_IDLE;
        if (busPop) begin
          dWrite <= aWrite;
          dWdata <= memWdata[rdPtr];
        end
      end else if (errFirst) begin
        dState <= DS_ERR;
      end

      rspValid <= 1'b0;
      rspErr   <= 1'b0;
      rspRdata <= '0;
      if (bus.iHREADY && (dState != DS_IDLE)) begin
        rspValid <= 1'b1;
        rspErr   <= (bus.iHRESP == HRESP_ERROR);
        rspRdata <= dWrite ? 32'h0 : bus.iHRDATA;
      end else if (localPop) begin
        rspValid <= 1'b1;
        rspErr   <= 1'b1;
      end
    end
  end

  assign bus.oHSEL     = aValid;
  assign bus.oHTRANS   = aValid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.oHWRITE   = aWrite;
  assign bus.oHADDR    = aAddr;
  assign bus.oHSIZE    = 3'b010;
  assign bus.oHWDATA   = dWdata;
  assign bus.oRspValid = rspValid;
  assign bus.oRspErr   = rspErr;
  assign bus.oRspRdata = rspRdata;
  assign bus.oBusy     = (count != '0) || aValid || (dState != DS_IDLE);
  assign oDbgState     = dState;
endmodule

// File: doc/ahb_cmd_master.md
# ahb_cmd_master

Synthesizable AHB-Lite initiator. It converts a simple valid/ready command stream (single 32-bit word reads and writes) into AHB NONSEQ transfers toward the AHB-to-APB bridge slave. It returns one response per command, carrying read data and an error flag. It sits between on-chip control logic and the AHB decoder/mux, and replaces the behavioural bus driver in system-level simulation.

## Interface
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iCmdValid  in  1  command present.
- oCmdReady  out  1  FIFO not full; command accepted when iCmdValid && oCmdReady.
- iCmdWrite  in  1  1 = write, 0 = read.
- iCmdAddr  in  32  byte address.
- iCmdWdata  in  32  write data; ignored for reads.
- oRspValid  out  1  one-cycle response pulse; no backpressure.
- oRspRdata  out  32  read data; 0 for writes.
- oRspErr  out  1  transfer ended with ERROR, or was rejected locally.
- oBusy  out  1  FIFO non-empty or transfer in flight.
- oHSEL, oHTRANS[1:0], oHWRITE, oHADDR[31:0], oHSIZE[2:0], oHWDATA[31:0]  out  AHB master outputs. oHSIZE is constant 3'b010. oHSEL = (oHTRANS == NONSEQ).
- iHREADY  in  1  muxed bus HREADY.
- iHRDATA  in  32  read data.
- iHRESP  in  2  00 OKAY, 01 ERROR.

## Operation
- Reset values:
  - oHTRANS=IDLE; oHSEL, oHWRITE, oHADDR and oHWDATA are 0.
  - oRspValid, oRspRdata, oRspErr and oBusy are 0.
  - oCmdReady=1 from the first cycle after reset.
  - FIFO is empty.
- Address stage (registered):
  - When the FIFO head is valid and no ERROR first-cycle is in progress, drive NONSEQ with the head's address and write flag.
  - Hold all address-phase outputs stable while iHREADY=0.
  - Pop the head when NONSEQ && iHREADY=1. The transfer then moves into the data stage register (valid, write, wdata).
- Data stage:
  - oHWDATA = the data stage's wdata for the whole data phase, including wait states.
  - Completes on the first cycle with iHREADY=1.
- Pipelining: the next command's address phase overlaps the current data phase. Back-to-back transfers sustain one per cycle with zero wait states.
- Completion registers the response:
  - oRspValid=1.
  - oRspRdata=iHRDATA for reads, 0 for writes.
  - oRspErr=(iHRESP==ERROR).
- ERROR handling, two-cycle response:
  - On the cycle with iHREADY=0 and iHRESP=01 in the data stage, drive oHTRANS=IDLE next cycle. This cancels any pending address phase.
  - The cancelled command stays in the FIFO (it was not popped) and reissues after the ERROR completes.
- oCmdReady=0 when the FIFO is full. A simultaneous push and pop on a full FIFO is not accepted; ready is combinational from the count only.
- oBusy = FIFO non-empty || address-stage valid || data-stage valid.
- Reset mid-transfer: at the next edge the FIFO is flushed, the data stage is dropped, no response is issued, and all outputs return to reset values.

## Timing
- Command accepted at edge T, with FIFO previously empty and bus idle:
  - NONSEQ is visible in cycle T+1.
  - Zero wait states: data phase in T+2; oRspValid high in T+3.
- Each wait state (iHREADY=0) adds one cycle to the affected phase.
- Read latency is 3 cycles from acceptance to response with zero wait states. Write latency is the same.
- Responses are in command order, exactly one per accepted command.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. The count is log2(FIFO_DEPTH)+1 bits.

## Configuration
- AHB_MST_ALIGN_CHECK_EN defined:
  - A head entry with addr[1:0]≠0 is popped without a bus transfer; oHTRANS stays IDLE.
  - Its response is produced in order: oRspValid=1, oRspErr=1, oRspRdata=0. It issues only after earlier in-flight transfers have responded.
- Undefined: addresses pass unmodified to oHADDR; no local rejection.

## Test plan
- Single write 0x70008000 ← 0xDEADBEEF, slave zero-wait:
  - NONSEQ with oHWRITE=1 at T+1; oHWDATA=0xDEADBEEF at T+2.
  - oRspValid at T+3 with oRspErr=0 and oRspRdata=0.
- Read 0x7000803C, slave inserts 2 wait states then returns 0x12345678:
  - oHADDR held stable for the whole transfer.
  - oRspValid at T+5 with oRspRdata=0x12345678.
- Four back-to-back reads, 0x70008000 to 0x7000800C, zero-wait:
  - NONSEQ on 4 consecutive cycles.
  - 4 consecutive oRspValid pulses, in order.
- Write then read, slave returns ERROR on the write:
  - oHTRANS=IDLE during the ERROR second cycle.
  - Write response has oRspErr=1.
  - Read reissues afterwards and gets oRspErr=0.
- Hold iHREADY=0 and push 5 commands (FIFO_DEPTH=4):
  - oCmdReady drops after the FIFO fills.
  - All responses arrive in order after iHREADY rises.
  - Assert iRst mid-stream: no further oRspValid; outputs at reset values next cycle.
- With AHB_MST_ALIGN_CHECK_EN, read 0x70008002:
  - No NONSEQ issued.
  - oRspErr=1 and oRspRdata=0.
